// File: rtl/uut_present_adapter_if.sv
// Autotest UUT port group: operands and hold/abort in, folded result and done flag out.
interface uut_present_adapter_if #(
   parameter int BLOCK_W  = 64,
   parameter int KEY_W    = 80,
   parameter int OUTPUT_W = 32
);
   logic                rst_uut;
   logic [BLOCK_W-1:0]  block_i_uut;
   logic [KEY_W-1:0]    key_uut;
   logic                encdec_uut;
   logic [OUTPUT_W-1:0] block_o_uut;
   logic                end_uut;

   modport master (
      output rst_uut, block_i_uut, key_uut, encdec_uut,
      input  block_o_uut, end_uut
   );
   modport slave (
      input  rst_uut, block_i_uut, key_uut, encdec_uut,
      output block_o_uut, end_uut
   );
endinterface

// File: rtl/uut_present_adapter.sv
// Adapter between the autotest UUT port group and a PRESENT core: operand capture,
// core run window sequencing, latency count with timeout, and output folding.
module uut_present_adapter #(
   parameter int BLOCK_W        = 64,
   parameter int KEY_W          = 80,
   parameter int OUTPUT_W       = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   uut_present_adapter_if.slave uut,
   output logic                core_rst,
   output logic [BLOCK_W-1:0]  core_block_i,
   output logic [KEY_W-1:0]    core_key,
   output logic                core_encdec,
   input  logic [BLOCK_W-1:0]  core_block_o,
   input  logic                core_end,
   output logic [31:0]         cycle_count,
   output logic                timeout
);
   localparam int          SLICES = BLOCK_W / OUTPUT_W;
   localparam logic [31:0] TMO    = 32'(TIMEOUT_CYCLES);

   if (BLOCK_W % OUTPUT_W != 0) begin : g_bad_width
      $error("BLOCK_W must be a multiple of OUTPUT_W");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {IDLE, CAPTURE, RUN, DONE} state_t;

   state_t              state, state_nxt;
   logic [31:0]         cnt_inc;
   logic                tmo_hit;
   logic [OUTPUT_W-1:0] fold;
   logic [OUTPUT_W-1:0] res_q;
   logic                end_q;

   assign uut.block_o_uut = res_q;
   assign uut.end_uut     = end_q;

   always_comb begin
      fold = '0;
      for (int i = 0; i < SLICES; i++) fold ^= core_block_o[i*OUTPUT_W +: OUTPUT_W];
   end

   // Saturating increment; terminal count is judged on the value this cycle will commit.
   assign cnt_inc = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
   assign tmo_hit = (cnt_inc >= TMO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      core_rst  = 1'b1;
      case (state)
         IDLE:    if (!uut.rst_uut) state_nxt = CAPTURE;
         CAPTURE: state_nxt = uut.rst_uut ? IDLE : RUN;
         RUN: begin
            core_rst = 1'b0;
            if (uut.rst_uut)              state_nxt = IDLE;
            else if (core_end || tmo_hit) state_nxt = DONE;
         end
         DONE:    if (uut.rst_uut) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_block_i <= '0;
         core_key     <= '0;
         core_encdec  <= 1'b0;
         cycle_count  <= '0;
         timeout      <= 1'b0;
         res_q        <= '0;
         end_q        <= 1'b0;
      end else begin
         if (state_nxt == IDLE) begin
            res_q <= '0;
            end_q <= 1'b0;
         end
         if (state == CAPTURE) begin
            core_block_i <= uut.block_i_uut;
            core_key     <= uut.key_uut;
            core_encdec  <= uut.encdec_uut;
            cycle_count  <= '0;
            timeout      <= 1'b0;
         end
         // An abort cycle is not counted and never produces a result.
         if (state == RUN && !uut.rst_uut) begin
            cycle_count <= cnt_inc;
            if (core_end) begin
               res_q <= fold;
               end_q <= 1'b1;
            end else if (tmo_hit) begin
               res_q   <= '1;
               end_q   <= 1'b1;
               timeout <= 1'b1;
            end
         end
      end
   end
endmodule
